lut_config_loader: RTL and testbench



---
 rtl/lut_config_loader.sv | 138 +++++++++++++
 tb/tb_lut_config_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_config_loader.sv
// LUT configuration loader: pairs stream words into 33-bit LUT images,
// writes them one LUT per pass slot, then validates an XOR checksum.
module lut_config_loader #(
  parameter int NUM_LUTS = 6,
  parameter int ADDR_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [32:0]       cfg_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              fabric_en
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LO    = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LUTS - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       xor_q, xor_d;
  logic [31:0]       table_q, table_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [32:0]       data_q, data_d;
  logic              accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    cfg_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      S_LO, S_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WR: begin
        cfg_we = 1'b1;
        busy   = 1'b1;
      end
      S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:  done  = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  assign fabric_en = done;
  assign cfg_addr  = addr_q;
  assign cfg_data  = data_q;

  // The image is staged on the high-word accept so it is stable in WRITE
  // and simply holds afterwards.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    table_d = table_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LO;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      S_LO: begin
        if (accept) begin
          table_d = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          xor_d   = xor_q ^ in_data;
          addr_d  = idx_q;
          data_d  = {in_data[0], table_q};
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_CHK;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_LO;
        end
      end
      S_CHK: begin
        if (accept) begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      xor_q   <= '0;
      table_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      table_q <= table_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: clean, mode, bad checksum,
// stalls, restart and mid-pass reset.
module tb_lut_config_loader;

  localparam int N  = 6;
  localparam int AW = 3;

  logic          clock;
  logic          reset;
  logic          start;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [32:0]   cfg_data;
  logic          busy;
  logic          done;
  logic          error;
  logic          fabric_en;

  lut_config_loader #(.NUM_LUTS(N), .ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .fabric_en (fabric_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   words   [0:12];
  logic [AW-1:0] wr_addr [0:63];
  logic [32:0]   wr_data [0:63];
  int            wr_n   = 0;
  int            we_rdy = 0;

  // Write-port logger, sampled after the edge has settled
  always @(posedge clock) begin
    #2;
    if (cfg_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = cfg_addr;
        wr_data[wr_n] = cfg_data;
      end
      wr_n++;
      if (in_ready) we_rdy++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_words(input logic [31:0] csum, input logic [31:0] w2);
    for (int i = 0; i < 12; i++) words[i] = 32'(i + 1);
    words[1]  = w2;
    words[12] = csum;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drive(input bit toggle, input int start_at, input int rst_w,
                       input int base, output int cyc, output int got);
    int k;
    int g;
    bit acc;
    k = 0;
    g = 0;
    while (k < 13 && g < 200) begin
      if (rst_w > 0 && wr_n - base >= rst_w) begin
        reset = 1'b1;
        break;
      end
      in_valid = toggle ? ~g[0] : 1'b1;
      in_data  = words[k];
      start    = (g == start_at);
      acc      = in_valid && in_ready;
      @(negedge clock);
      if (acc) k++;
      g++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    cyc      = g;
    got      = k;
  endtask

  task automatic check_writes(input string tag, input int base);
    logic [32:0] img;
    chk({tag, "_nwr"}, 64'(wr_n - base), 64'(N));
    for (int i = 0; i < N; i++) begin
      img = {words[2*i+1][0], words[2*i]};
      chk({tag, "_addr"}, 64'(wr_addr[base+i]), 64'(i));
      chk({tag, "_data"}, 64'(wr_data[base+i]), 64'(img));
    end
  endtask

  initial begin
    int base;
    int cyc;
    int got;
    int rdy0;

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clock);
    chk("rst_flags",
        64'({in_ready, cfg_we, busy, done, error, fabric_en}), 64'd0);
    chk("rst_addr", 64'(cfg_addr), 64'd0);
    chk("rst_data", 64'(cfg_data), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Clean load
    load_words(32'h0000000C, 32'h2);
    base = wr_n;
    rdy0 = we_rdy;
    pulse_start();
    chk("t1_busy", 64'({busy, in_ready}), 64'b11);
    drive(1'b0, -1, 0, base, cyc, got);
    chk("t1_words", 64'(got), 64'd13);
    chk("t1_cycles", 64'(cyc), 64'd19);
    chk("t1_result",
        64'({done, fabric_en, error, busy}), 64'b1100);
    check_writes("t1", base);
    chk("t1_first", 64'(wr_data[base]), 64'h000000001);
    chk("t1_last", 64'(wr_data[base+5]), 64'h00000000B);
    chk("t1_we_rdy", 64'(we_rdy - rdy0), 64'd0);

    // Mode bit; XOR of the stream is 32'hFFFFFFF1
    load_words(32'hFFFFFFF1, 32'hFFFFFFFF);
    base = wr_n;
    pulse_start();
    drive(1'b0, -1, 0, base, cyc, got);
    chk("t2_img0", 64'(wr_data[base]), 64'h100000001);
    chk("t2_result", 64'({done, fabric_en, error}), 64'b110);
    check_writes("t2", base);

    // Bad checksum
    load_words(32'h0000000D, 32'h2);
    base = wr_n;
    pulse_start();
    drive(1'b0, -1, 0, base, cyc, got);
    chk("t3_result", 64'({done, fabric_en, error}), 64'b001);
    check_writes("t3", base);

    // Stalls on every other cycle
    load_words(32'h0000000C, 32'h2);
    base = wr_n;
    rdy0 = we_rdy;
    pulse_start();
    chk("t4_err_clr", 64'({error, done}), 64'b00);
    drive(1'b1, -1, 0, base, cyc, got);
    chk("t4_words", 64'(got), 64'd13);
    chk("t4_result", 64'({done, fabric_en, error}), 64'b110);
    check_writes("t4", base);
    chk("t4_we_rdy", 64'(we_rdy - rdy0), 64'd0);

    // Restart from DONE, with a start pulse inside the pass
    base = wr_n;
    pulse_start();
    chk("t5_drop", 64'({done, fabric_en, busy}), 64'b001);
    drive(1'b0, 5, 0, base, cyc, got);
    chk("t5_cycles", 64'(cyc), 64'd19);
    chk("t5_result", 64'({done, fabric_en, error}), 64'b110);
    check_writes("t5", base);
    base = wr_n;
    pulse_start();
    chk("t5b_drop", 64'({done, fabric_en}), 64'b00);
    drive(1'b0, -1, 0, base, cyc, got);
    chk("t5b_result", 64'({done, fabric_en, error}), 64'b110);
    check_writes("t5b", base);

    // Reset after the third write
    base = wr_n;
    pulse_start();
    drive(1'b0, -1, 3, base, cyc, got);
    @(negedge clock);
    chk("t6_flags",
        64'({in_ready, cfg_we, busy, done, error, fabric_en}), 64'd0);
    chk("t6_addr", 64'(cfg_addr), 64'd0);
    chk("t6_data", 64'(cfg_data), 64'd0);
    chk("t6_nwr", 64'(wr_n - base), 64'd3);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t6_idle_rdy", 64'({in_ready, busy}), 64'd0);
    end
    in_valid = 1'b0;
    base = wr_n;
    pulse_start();
    drive(1'b0, -1, 0, base, cyc, got);
    chk("t6_result", 64'({done, fabric_en, error}), 64'b110);
    check_writes("t6", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
